// File: rtl/frame_scheduler.sv
// Frame sequencer for the draw path: queues host primitives, clears the back
// buffer, issues each primitive to the draw engine, then swaps buffers.
module frame_scheduler #(
   parameter int          FIFO_DEPTH = 16,
   parameter logic [31:0] BUF0_ADDR  = 32'h00000000,
   parameter logic [31:0] BUF1_ADDR  = 32'h0012C000
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_opcode,
   input  logic [15:0] cmd_ax,
   input  logic [15:0] cmd_ay,
   input  logic [15:0] cmd_bx,
   input  logic [15:0] cmd_by,
   input  logic [15:0] cmd_cx,
   input  logic [15:0] cmd_cy,
   input  logic [31:0] cmd_colour,
   input  logic        cmd_last,
   input  logic        frame_go,
   input  logic        frame_sync,
   output logic        clear_start,
   input  logic        clear_done,
   output logic        draw_en,
   output logic [3:0]  draw_opcode,
   output logic [15:0] draw_ax,
   output logic [15:0] draw_ay,
   output logic [15:0] draw_bx,
   output logic [15:0] draw_by,
   output logic [15:0] draw_cx,
   output logic [15:0] draw_cy,
   output logic [31:0] draw_colour,
   input  logic        draw_done,
   output logic        swap_buffer,
   output logic [31:0] base_addr,
   output logic        busy,
   output logic [15:0] frame_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = 133;

   typedef enum logic [2:0] {
      IDLE, CLEAR_START, CLEAR_WAIT, FETCH, DRAW_START, DRAW_WAIT, SWAP, SYNC_WAIT
   } state_t;

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          full;
   logic          push;
   logic          pop;
   logic [EW-1:0] head;
   logic [PW-1:0] frames_pending;
   logic          go_pending;
   logic          cur_last;
   state_t        state;

   // Full when the pointers differ only in the wrap bit.
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_ready = ~full;
   assign push      = cmd_valid & ~full;
   assign pop       = (state == FETCH);
   assign head      = mem[rd_ptr[AW-1:0]];

   // Command storage write port.
   always_ff @(posedge sys_clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {cmd_opcode, cmd_ax, cmd_ay, cmd_bx, cmd_by,
                                 cmd_cx, cmd_cy, cmd_colour, cmd_last};
      end
   end

   // FIFO pointers and count of complete frames queued.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         wr_ptr         <= {(AW+1){1'b0}};
         rd_ptr         <= {(AW+1){1'b0}};
         frames_pending <= {PW{1'b0}};
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
         case ({push & cmd_last, pop & head[0]})
            2'b10:   frames_pending <= frames_pending + PW'(1);
            2'b01:   frames_pending <= frames_pending - PW'(1);
            default: frames_pending <= frames_pending;
         endcase
      end
   end

   // Frame sequencer; strobes are set on entry to their state so they are clean registers.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state       <= IDLE;
         go_pending  <= 1'b0;
         cur_last    <= 1'b0;
         clear_start <= 1'b0;
         draw_en     <= 1'b0;
         swap_buffer <= 1'b0;
         busy        <= 1'b0;
         draw_opcode <= 4'd0;
         draw_ax     <= 16'd0;
         draw_ay     <= 16'd0;
         draw_bx     <= 16'd0;
         draw_by     <= 16'd0;
         draw_cx     <= 16'd0;
         draw_cy     <= 16'd0;
         draw_colour <= 32'd0;
         base_addr   <= BUF1_ADDR;
         frame_count <= 16'd0;
      end else begin
         clear_start <= 1'b0;
         draw_en     <= 1'b0;
         swap_buffer <= 1'b0;
         if (frame_go) go_pending <= 1'b1;
         case (state)
            IDLE: begin
               if ((go_pending | frame_go) && (frames_pending != {PW{1'b0}})) begin
                  state       <= CLEAR_START;
                  clear_start <= 1'b1;
                  busy        <= 1'b1;
                  go_pending  <= 1'b0;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            CLEAR_START: state <= CLEAR_WAIT;
            CLEAR_WAIT: begin
               if (clear_done) state <= FETCH;
            end
            FETCH: begin
               {draw_opcode, draw_ax, draw_ay, draw_bx, draw_by,
                draw_cx, draw_cy, draw_colour, cur_last} <= head;
               if (head[EW-1:EW-4] != 4'd0) begin
                  state   <= DRAW_START;
                  draw_en <= 1'b1;
               end else if (head[0]) begin
                  state       <= SWAP;
                  swap_buffer <= 1'b1;
               end else begin
                  state <= FETCH;
               end
            end
            DRAW_START: state <= DRAW_WAIT;
            DRAW_WAIT: begin
               if (draw_done) begin
                  if (cur_last) begin
                     state       <= SWAP;
                     swap_buffer <= 1'b1;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            SWAP: begin
               base_addr   <= (base_addr == BUF0_ADDR) ? BUF1_ADDR : BUF0_ADDR;
               frame_count <= frame_count + 16'd1;
               state       <= SYNC_WAIT;
            end
            SYNC_WAIT: begin
               if (frame_sync) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: scoreboard of queued primitives checked
// against every draw_en, plus strobe counts, latencies and reset state.
module tb_frame_scheduler;

   logic        sys_clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_opcode = 4'd0;
   logic [15:0] cmd_ax = 16'd0, cmd_ay = 16'd0, cmd_bx = 16'd0;
   logic [15:0] cmd_by = 16'd0, cmd_cx = 16'd0, cmd_cy = 16'd0;
   logic [31:0] cmd_colour = 32'd0;
   logic        cmd_last = 1'b0;
   logic        frame_go = 1'b0;
   logic        frame_sync = 1'b0;
   logic        clear_start;
   logic        clear_done = 1'b0;
   logic        draw_en;
   logic [3:0]  draw_opcode;
   logic [15:0] draw_ax, draw_ay, draw_bx, draw_by, draw_cx, draw_cy;
   logic [31:0] draw_colour;
   logic        draw_done = 1'b0;
   logic        swap_buffer;
   logic [31:0] base_addr;
   logic        busy;
   logic [15:0] frame_count;

   frame_scheduler dut (
      .sys_clk(sys_clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_ax(cmd_ax), .cmd_ay(cmd_ay), .cmd_bx(cmd_bx), .cmd_by(cmd_by),
      .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .cmd_colour(cmd_colour), .cmd_last(cmd_last),
      .frame_go(frame_go), .frame_sync(frame_sync),
      .clear_start(clear_start), .clear_done(clear_done),
      .draw_en(draw_en), .draw_opcode(draw_opcode),
      .draw_ax(draw_ax), .draw_ay(draw_ay), .draw_bx(draw_bx), .draw_by(draw_by),
      .draw_cx(draw_cx), .draw_cy(draw_cy), .draw_colour(draw_colour),
      .draw_done(draw_done), .swap_buffer(swap_buffer), .base_addr(base_addr),
      .busy(busy), .frame_count(frame_count)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   int checks = 0;
   int fails  = 0;
   logic [131:0] sb[$];
   int n_clear = 0, n_draw = 0, n_swap = 0, clear_cyc = -1, swap_cyc = -1;
   int push_cyc, go_cyc, clr_done_cyc;

   task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Output monitor: strobe counters and scoreboard check of every issued primitive.
   always @(negedge sys_clk) begin
      if (clear_start) begin
         n_clear   <= n_clear + 1;
         clear_cyc <= cyc;
      end
      if (swap_buffer) begin
         n_swap   <= n_swap + 1;
         swap_cyc <= cyc;
      end
      if (draw_en) begin
         n_draw <= n_draw + 1;
         chk("draw_expected", {131'd0, sb.size() != 0}, 132'd1);
         if (sb.size() != 0)
            chk("draw_operands", {draw_opcode, draw_ax, draw_ay, draw_bx, draw_by,
                                  draw_cx, draw_cy, draw_colour}, sb.pop_front());
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic push(input logic [3:0] op, input bit last, output bit acc);
      logic [127:0] v;
      v = {$urandom, $urandom, $urandom, $urandom};
      cmd_opcode = op;
      {cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy, cmd_colour} = v;
      cmd_last  = last;
      cmd_valid = 1'b1;
      push_cyc  = cyc;
      acc       = cmd_ready;
      if (acc && op != 4'd0) sb.push_back({op, v});
      tick();
      cmd_valid = 1'b0;
      cmd_last  = 1'b0;
   endtask

   // Plays SDRAM/draw/display responder (5-cycle clear and draw, 3-cycle sync).
   task automatic run_frame(input int max, input bit pulse_go, input bit stop_in_draw,
                            output bit ok);
      int cdc = 0, cdd = 0, cds = 0;
      bit seen_swap = 1'b0;
      ok = 1'b0;
      if (pulse_go) begin
         frame_go = 1'b1;
         go_cyc   = cyc;
      end
      for (int i = 0; i < max; i++) begin
         tick();
         frame_go = 1'b0; clear_done = 1'b0; draw_done = 1'b0; frame_sync = 1'b0;
         if (clear_start) cdc = 5;
         else if (cdc > 0) begin
            cdc--;
            if (cdc == 0) begin clear_done = 1'b1; clr_done_cyc = cyc; end
         end
         if (draw_en) begin
            if (stop_in_draw) begin tick(); ok = 1'b1; break; end
            cdd = 5;
         end else if (cdd > 0) begin
            cdd--;
            if (cdd == 0) draw_done = 1'b1;
         end
         if (swap_buffer) begin seen_swap = 1'b1; cds = 3; end
         else if (cds > 0) begin
            cds--;
            if (cds == 0) frame_sync = 1'b1;
         end
         if (seen_swap && !busy) begin ok = 1'b1; break; end
      end
      frame_go = 1'b0; clear_done = 1'b0; draw_done = 1'b0; frame_sync = 1'b0;
   endtask

   initial begin
      bit acc, ok;
      int c0, d0, s0;

      // Reset values
      do_reset();
      chk("rst_cmd_ready", {131'd0, cmd_ready}, 132'd1);
      chk("rst_busy", {131'd0, busy}, 132'd0);
      chk("rst_base_addr", {100'd0, base_addr}, {100'd0, 32'h0012C000});
      chk("rst_frame_count", {116'd0, frame_count}, 132'd0);
      chk("rst_pulses", {129'd0, clear_start, draw_en, swap_buffer}, 132'd0);
      chk("rst_operands", {draw_opcode, draw_ax, draw_ay, draw_bx, draw_by,
                           draw_cx, draw_cy, draw_colour}, 132'd0);

      // Two-triangle frame
      c0 = n_clear; d0 = n_draw; s0 = n_swap;
      push(4'd3, 1'b0, acc);
      push(4'd5, 1'b1, acc);
      run_frame(200, 1'b1, 1'b0, ok);
      chk("tri2_done", {131'd0, ok}, 132'd1);
      chk("tri2_clear_lat", clear_cyc, go_cyc + 1);
      chk("tri2_n_clear", n_clear - c0, 132'd1);
      chk("tri2_n_draw", n_draw - d0, 132'd2);
      chk("tri2_n_swap", n_swap - s0, 132'd1);
      chk("tri2_base_addr", {100'd0, base_addr}, 132'd0);
      chk("tri2_frame_count", {116'd0, frame_count}, 132'd1);
      chk("tri2_sb_empty", sb.size(), 132'd0);

      // Early frame_go on an empty FIFO
      c0 = n_clear; d0 = n_draw;
      frame_go = 1'b1;
      tick();
      frame_go = 1'b0;
      repeat (10) tick();
      chk("early_idle", {131'd0, busy}, 132'd0);
      chk("early_no_clear", n_clear - c0, 132'd0);
      push(4'd7, 1'b1, acc);
      run_frame(200, 1'b0, 1'b0, ok);
      chk("early_done", {131'd0, ok}, 132'd1);
      chk("early_clear_lat", clear_cyc, push_cyc + 2);
      chk("early_n_draw", n_draw - d0, 132'd1);
      chk("early_base_addr", {100'd0, base_addr}, {100'd0, 32'h0012C000});
      chk("early_frame_count", {116'd0, frame_count}, 132'd2);

      // NOP-only frame
      c0 = n_clear; d0 = n_draw;
      push(4'd0, 1'b1, acc);
      run_frame(200, 1'b1, 1'b0, ok);
      chk("nop_done", {131'd0, ok}, 132'd1);
      chk("nop_n_clear", n_clear - c0, 132'd1);
      chk("nop_n_draw", n_draw - d0, 132'd0);
      chk("nop_swap_lat", swap_cyc, clr_done_cyc + 2);
      chk("nop_frame_count", {116'd0, frame_count}, 132'd3);

      // Backpressure: 16 non-last entries fill the FIFO
      c0 = n_clear;
      for (int i = 0; i < 16; i++) begin
         push(4'd1 + 4'(i % 15), 1'b0, acc);
         chk("bp_accept", {131'd0, acc}, 132'd1);
      end
      chk("bp_full", {131'd0, cmd_ready}, 132'd0);
      cmd_valid = 1'b1;
      cmd_opcode = 4'd9;
      for (int i = 0; i < 4; i++) begin
         chk("bp_17th_refused", {131'd0, cmd_ready}, 132'd0);
         tick();
      end
      cmd_valid = 1'b0;
      frame_go = 1'b1;
      tick();
      frame_go = 1'b0;
      repeat (5) tick();
      chk("bp_go_ignored", {131'd0, busy}, 132'd0);
      chk("bp_no_clear", n_clear - c0, 132'd0);
      do_reset();
      chk("bp_reset_ready", {131'd0, cmd_ready}, 132'd1);

      // Reset mid-frame while waiting on the draw engine
      d0 = n_draw;
      push(4'd2, 1'b0, acc);
      push(4'd4, 1'b1, acc);
      run_frame(200, 1'b1, 1'b1, ok);
      chk("mid_reached_draw", {131'd0, ok}, 132'd1);
      chk("mid_busy_in_draw", {131'd0, busy}, 132'd1);
      do_reset();
      chk("mid_rst_busy", {131'd0, busy}, 132'd0);
      chk("mid_rst_ready", {131'd0, cmd_ready}, 132'd1);
      chk("mid_rst_frame_count", {116'd0, frame_count}, 132'd0);
      chk("mid_rst_base_addr", {100'd0, base_addr}, {100'd0, 32'h0012C000});
      chk("mid_rst_operands", {draw_opcode, draw_ax, draw_ay, draw_bx, draw_by,
                               draw_cx, draw_cy, draw_colour}, 132'd0);
      c0 = n_clear; d0 = n_draw;
      frame_go = 1'b1;
      tick();
      frame_go = 1'b0;
      tick();
      chk("mid_flushed_no_start", {131'd0, busy}, 132'd0);
      push(4'd6, 1'b1, acc);
      run_frame(200, 1'b1, 1'b0, ok);
      chk("mid_new_done", {131'd0, ok}, 132'd1);
      chk("mid_new_n_clear", n_clear - c0, 132'd1);
      chk("mid_new_n_draw", n_draw - d0, 132'd1);
      chk("mid_new_frame_count", {116'd0, frame_count}, 132'd1);
      chk("mid_new_base_addr", {100'd0, base_addr}, 132'd0);
      chk("mid_new_sb_empty", sb.size(), 132'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Sequences one rendered frame on the draw path: buffers primitive commands from a host in an internal FIFO, clears the back buffer through the SDRAM interface, issues each queued primitive to the `draw` engine, then requests a buffer swap and waits for the display frame boundary. It sits between the host/command source and the `draw` engine and SDRAM interface, replacing ad-hoc clear/draw/swap sequencing in top-levels.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: command FIFO entries; power of two, at least 2.
- `BUF0_ADDR`, 32'h00000000: buffer 0 base address.
- `BUF1_ADDR`, 32'h0012C000: buffer 1 base address.

Ports:
- `sys_clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1, `cmd_ready` out 1: command push handshake.
- `cmd_opcode` in 4: opcode; 0 = NOP, never forwarded.
- `cmd_ax`, `cmd_ay`, `cmd_bx`, `cmd_by`, `cmd_cx`, `cmd_cy` in 16 each: vertices.
- `cmd_colour` in 32: colour.
- `cmd_last` in 1: marks the final command of a frame.
- `frame_go` in 1: request to render the next frame (pulse).
- `frame_sync` in 1: one-cycle pulse at the display frame boundary (swap taken).
- `clear_start` out 1: one-cycle clear request to the SDRAM interface.
- `clear_done` in 1: clear complete pulse.
- `draw_en` out 1: one-cycle start to the `draw` engine.
- `draw_opcode` out 4, `draw_ax`…`draw_cy` out 16, `draw_colour` out 32: operands.
- `draw_done` in 1: primitive complete pulse.
- `swap_buffer` out 1: one-cycle swap request.
- `base_addr` out 32: back-buffer base address.
- `busy` out 1: high in any state other than IDLE.
- `frame_count` out 16: frames completed, wraps at 65535 to 0.

## Operation
- FIFO holds `{opcode, 6 coords, colour, last}`. `cmd_ready` = not full. A push occurs when `cmd_valid & cmd_ready`.
- Simultaneous push and pop on a full FIFO:
  - The pop occurs, but `cmd_ready` is computed from the pre-pop state (0).
  - The push is not accepted.
- `frames_pending` counter, width clog2(FIFO_DEPTH+1):
  - +1 on a push with `last` set.
  - −1 on a pop with `last` set.
  - Both at once: no change.
- `go_pending` flag:
  - Set by `frame_go`.
  - Cleared on the IDLE→CLEAR_START transition.
  - Repeated `frame_go` pulses before the flag is consumed coalesce into one request.
- States:
  - IDLE: go to CLEAR_START when `go_pending`, or `frame_go` this cycle, and `frames_pending != 0`. Otherwise stay.
  - CLEAR_START: `clear_start`=1. Next state CLEAR_WAIT.
  - CLEAR_WAIT: on `clear_done`, go to FETCH.
  - FETCH:
    - Pop the head entry and register it into the `draw_*` operand registers.
    - If opcode ≠ 0, go to DRAW_START.
    - Else if `last`, go to SWAP; else stay in FETCH.
  - DRAW_START: `draw_en`=1. Next state DRAW_WAIT.
  - DRAW_WAIT: on `draw_done`, go to SWAP if the current entry had `last`, else FETCH.
  - SWAP:
    - `swap_buffer`=1.
    - `base_addr` toggles between BUF0_ADDR and BUF1_ADDR at the end of this cycle.
    - `frame_count` +1.
    - Next state SYNC_WAIT.
  - SYNC_WAIT: on `frame_sync`, go to IDLE.
- FETCH never sees an empty FIFO, because `frames_pending != 0` guarantees a complete frame is queued.
- `clear_done`, `draw_done` and `frame_sync` are ignored outside their wait states.
- `cmd_*` pushes remain legal in every state.
- Reset, including mid-frame:
  - FIFO flushed; `frames_pending`=0; `go_pending`=0; state IDLE.
  - All pulse outputs 0; `draw_*` operands 0.
  - `base_addr`=BUF1_ADDR; `frame_count`=0; `busy`=0; `cmd_ready`=1.

## Timing
- `clear_start`, `draw_en`, `swap_buffer` and `busy` are Moore outputs decoded from the registered state, glitch-free for one cycle each.
- `frame_go` high in cycle N, with IDLE and a frame pending → `clear_start` high in cycle N+1.
- `clear_done` in cycle N → pop in cycle N+1 (FETCH) → `draw_en` in cycle N+2.
- `draw_*` operands:
  - Become valid at the `draw_en` cycle.
  - Hold stable until the next FETCH.
- `draw_done` in cycle N:
  - → FETCH in cycle N+1 if not last.
  - → `swap_buffer` in cycle N+1 if last.
- Each NOP entry costs one FETCH cycle.
- A pushed entry is visible to FETCH one cycle after its push.
- `frames_pending` updates one cycle after the push, so an IDLE start can begin one cycle after the `last` push.

## Test plan
- **Reset values:** drive `reset` high for 2 cycles → `cmd_ready`=1, `busy`=0, `base_addr`=32'h0012C000, `frame_count`=0, all pulse outputs 0.
- **Two-triangle frame:**
  - Stimulus: push 2 triangles, the second with `last`; pulse `frame_go`; respond to `clear_done` and `draw_done` after 5 cycles each.
  - Expected: exactly 1 `clear_start`, 2 `draw_en` with the pushed operands in order, 1 `swap_buffer`, `base_addr`=0, `frame_count`=1; IDLE after `frame_sync`.
- **Early `frame_go`:**
  - Stimulus: pulse `frame_go` with an empty FIFO; 10 cycles later push a single `last` triangle.
  - Expected: `clear_start` 2 cycles after the push; one frame rendered.
- **NOP-only frame:** push a single NOP with `last`, then `frame_go` → clear, no `draw_en`, `swap_buffer` 2 cycles after `clear_done`.
- **Backpressure:**
  - Stimulus: fill 16 entries with no `last`; hold `cmd_valid` high.
  - Expected: `cmd_ready`=0 and the 17th entry is not accepted; `frame_go` has no effect while `frames_pending`=0.
- **Reset mid-frame:**
  - Stimulus: assert `reset` in DRAW_WAIT, then a new single-entry frame.
  - Expected: FIFO empty, `frame_count`=0, `base_addr`=32'h0012C000; the new frame renders normally.
